dtw_core_mq: RTL and testbench
==============================

// Module: dtw_core_mq
// PURPOSE
//  Multi-query sDTW controller. Runs up to MAX_QUERIES packed queries back-to-back against one loaded reference.
//  Sequences ref/query memory reads, drives an external dtw_core_datapath via the dp_* ports, and emits one result per query.
//  Results leave on a valid/ready interface with backpressure, a threshold-hit flag and a run watchdog.
//  Sits between the ref/query loaders and the result sink FIFO.
// PARAMETERS
//  WIDTH 16 : sample/score width
//  AXIS_WIDTH 32 : ref_len width
//  SQG_SIZE 250 : samples per query
//  QSTRIDE 256 : query-memory words per query slot; word 0 = query id, words 1..SQG_SIZE = samples
//  MAX_QUERIES 8 : query slots
//  REFMEM_PTR_WIDTH 15 : ref address width
//  QEUMEM_PTR_WIDTH 11 : query address width; must hold MAX_QUERIES*QSTRIDE
//  TO_SLACK 64 : watchdog slack cycles
// PORTS
//  clk  in  1  clock
//  rst  in  1  synchronous, active-high reset
//  start  in  1  begin batch; honoured only in IDLE with both load_done high
//  abort  in  1  return to IDLE next cycle from any state
//  cfg_nquery  in  $clog2(MAX_QUERIES)+1  queries in batch; sampled at start; 0 -> 1, >MAX_QUERIES -> MAX_QUERIES
//  cfg_threshold  in  WIDTH  hit threshold
//  busy  out  1  high in every state except IDLE
//  ref_mem_read  out  1  ref read enable
//  ref_read_addr  out  REFMEM_PTR_WIDTH  ref address
//  dataout_ref  in  WIDTH  ref data, 1-cycle read latency
//  ref_len  in  AXIS_WIDTH  ref length in samples
//  ref_load_done  in  1  ref memory valid
//  qeu_read_addr  out  QEUMEM_PTR_WIDTH  query address
//  dataout_qeu  in  WIDTH  query data, 1-cycle latency
//  qeu_load_done  in  1  query memory valid
//  dp_rst  out  1  datapath reset
//  dp_running  out  1  datapath run enable
//  dp_done  in  1  datapath done
//  dp_minval  in  WIDTH  datapath minimum score
//  dp_position  in  32  datapath best-match position
//  res_valid  out  1  result valid; held until res_ready
//  res_ready  in  1  sink ready
//  res_qeu_id  out  32  query id (zero-extended)
//  res_ref_id  out  32  ref id (zero-extended)
//  res_minval  out  WIDTH  minimum score
//  res_position  out  32  best-match position
//  res_hit  out  1  res_minval <= cfg_threshold
//  res_last  out  1  final query of batch
//  res_timeout  out  1  result forced by watchdog
//  dbg_state  out  3  FSM state
//  dbg_nquery  out  32  accepted results, saturating
//  dbg_first_qid  out  32  id of query slot 0 of the latest batch
// BEHAVIOUR
//  Reset: state IDLE; dp_rst=1; all other outputs, addresses, qidx, qbase and counters are 0.
//  States: IDLE=0, INIT=1, RUN=2, DONE=3, RESULT=4, WAIT=5.
//  IDLE: dp_rst=1, ref_read_addr=0, qeu_read_addr=qbase=0. start & ref_load_done & qeu_load_done -> INIT, qidx=0.
//   start without both load_done is dropped, not queued.
//  INIT (1 cycle): latch query id from dataout_qeu and ref id from dataout_ref; ref_read_addr<=1; qeu_read_addr<=qbase+1;
//   dp_rst<=0; dp_running<=1; ref_mem_read<=1; clear watchdog; if qidx==0, dbg_first_qid<=dataout_qeu. -> RUN.
//  RUN: ref_read_addr +1 per cycle. qeu_read_addr +1 while ref_read_addr < SQG_SIZE+2, then holds.
//   dp_done -> DONE.
//   watchdog > ref_len+SQG_SIZE+TO_SLACK -> DONE with timeout=1. On the same cycle, dp_done wins and timeout=0.
//  DONE (1 cycle): dp_running=0, ref_mem_read=0, ref_read_addr=0. Register dp_minval/dp_position and the ids;
//   res_hit, res_last=(qidx==nq-1), res_timeout; res_valid<=1. -> RESULT.
//  RESULT: res_* stable while res_valid & !res_ready. On res_valid & res_ready: res_valid<=0, dbg_nquery+1 (saturates);
//   if last -> IDLE, else qidx+1, qbase+=QSTRIDE, qeu_read_addr<=qbase+QSTRIDE, dp_rst<=1 -> WAIT.
//  WAIT (2 cycles, counter): dp_rst=1, addresses held to prime the 1-cycle reads. -> INIT.
//  abort (any state, highest priority after rst): -> IDLE next cycle; pending res_valid dropped; no partial result.
//  Width: ids zero-extended to 32; threshold compare unsigned WIDTH; qbase add must not overflow (param constraint).
// STRUCTURE
//  dtw_pkg: state localparams, WAIT_CYCLES=2, clog2 helper.
//  Sub-module dtw_res_slice: valid/ready holding register for the res_* bundle.
//  Datapath instantiated by parent, not here.
// TESTING
//  Reset mid-RUN -> next cycle IDLE, busy=0, res_valid=0, dp_rst=1, addresses 0.
//  cfg_nquery=3, res_ready=1 -> 3 results; qeu ids read at 0/256/512; res_last only on 3rd; dbg_nquery=3; then IDLE.
//  res_ready low 20 cycles on result 1 -> res_* stable, no WAIT entry; next query starts 3 cycles after handshake.
//  threshold=100, dp_minval 100 then 101 -> res_hit 1 then 0.
//  dp_done never asserted, ref_len=1000 -> DONE after 1315 RUN cycles, res_timeout=1.
//  abort during RESULT with res_valid=1 -> res_valid=0 next cycle, IDLE; start with qeu_load_done=0 ignored.

Source files
------------

// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared state encoding and helpers for the multi-query sDTW controller
package dtw_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_RUN    = 3'd2,
        S_DONE   = 3'd3,
        S_RESULT = 3'd4,
        S_WAIT   = 3'd5
    } dtw_state_t;

    localparam int WAIT_CYCLES = 2;

    function automatic int dtw_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/dtw_core_mq_if.sv
// rtl/dtw_core_mq_if.sv - result bundle with valid/ready handshake
interface dtw_core_mq_if #(
    parameter int WIDTH = 16
) ();
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_qeu_id;
    logic [31:0]      res_ref_id;
    logic [WIDTH-1:0] res_minval;
    logic [31:0]      res_position;
    logic             res_hit;
    logic             res_last;
    logic             res_timeout;

    modport master (
        output res_valid, res_qeu_id, res_ref_id, res_minval, res_position,
               res_hit, res_last, res_timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_qeu_id, res_ref_id, res_minval, res_position,
               res_hit, res_last, res_timeout,
        output res_ready
    );
endinterface

// File: rtl/dtw_res_slice.sv
// rtl/dtw_res_slice.sv - holding register for the result bundle until the sink accepts it
module dtw_res_slice #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [31:0]      qeu_id,
    input  logic [31:0]      ref_id,
    input  logic [WIDTH-1:0] minval,
    input  logic [31:0]      position,
    input  logic             hit,
    input  logic             last,
    input  logic             timeout,
    dtw_core_mq_if.master    res
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            res.res_valid    <= 1'b0;
            res.res_qeu_id   <= '0;
            res.res_ref_id   <= '0;
            res.res_minval   <= '0;
            res.res_position <= '0;
            res.res_hit      <= 1'b0;
            res.res_last     <= 1'b0;
            res.res_timeout  <= 1'b0;
        end else if (load) begin
            res.res_valid    <= 1'b1;
            res.res_qeu_id   <= qeu_id;
            res.res_ref_id   <= ref_id;
            res.res_minval   <= minval;
            res.res_position <= position;
            res.res_hit      <= hit;
            res.res_last     <= last;
            res.res_timeout  <= timeout;
        end else if (res.res_valid && res.res_ready) begin
            res.res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dtw_core_mq.sv
// rtl/dtw_core_mq.sv - sequences back-to-back sDTW queries against one reference and emits one result each
module dtw_core_mq
    import dtw_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int AXIS_WIDTH       = 32,
    parameter int SQG_SIZE         = 250,
    parameter int QSTRIDE          = 256,
    parameter int MAX_QUERIES      = 8,
    parameter int REFMEM_PTR_WIDTH = 15,
    parameter int QEUMEM_PTR_WIDTH = 11,
    parameter int TO_SLACK         = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [dtw_clog2(MAX_QUERIES):0] cfg_nquery,
    input  logic [WIDTH-1:0]              cfg_threshold,
    output logic                          busy,
    output logic                          ref_mem_read,
    output logic [REFMEM_PTR_WIDTH-1:0]   ref_read_addr,
    input  logic [WIDTH-1:0]              dataout_ref,
    input  logic [AXIS_WIDTH-1:0]         ref_len,
    input  logic                          ref_load_done,
    output logic [QEUMEM_PTR_WIDTH-1:0]   qeu_read_addr,
    input  logic [WIDTH-1:0]              dataout_qeu,
    input  logic                          qeu_load_done,
    output logic                          dp_rst,
    output logic                          dp_running,
    input  logic                          dp_done,
    input  logic [WIDTH-1:0]              dp_minval,
    input  logic [31:0]                   dp_position,
    dtw_core_mq_if.master                 res,
    output logic [2:0]                    dbg_state,
    output logic [31:0]                   dbg_nquery,
    output logic [31:0]                   dbg_first_qid
);

    localparam int NQ_W = dtw_clog2(MAX_QUERIES) + 1;
    localparam int LW   = AXIS_WIDTH + 2;

    dtw_state_t                  state, state_nxt;
    logic [NQ_W-1:0]             nq, qidx, nq_clamped;
    logic [QEUMEM_PTR_WIDTH-1:0] qbase;
    logic [AXIS_WIDTH:0]         wdog;
    logic [1:0]                  wait_cnt;
    logic [WIDTH-1:0]            qid, rid;
    logic                        timed_out;
    logic [LW-1:0]               wd_limit, wd_run;
    logic                        wd_expired, res_fire, slice_load, slice_clear;

    // wd_run counts RUN cycles including the current one
    assign wd_limit   = LW'(ref_len) + LW'(SQG_SIZE + TO_SLACK);
    assign wd_run     = LW'(wdog) + LW'(1);
    assign wd_expired = wd_run > wd_limit;
    assign res_fire   = res.res_valid && res.res_ready;
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;

    always_comb begin
        nq_clamped = cfg_nquery;
        if (cfg_nquery == '0)
            nq_clamped = NQ_W'(1);
        else if (cfg_nquery > NQ_W'(MAX_QUERIES))
            nq_clamped = NQ_W'(MAX_QUERIES);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        slice_load  = 1'b0;
        slice_clear = abort;
        case (state)
            S_IDLE:   if (start && ref_load_done && qeu_load_done) state_nxt = S_INIT;
            S_INIT:   state_nxt = S_RUN;
            S_RUN:    if (dp_done || wd_expired) state_nxt = S_DONE;
            S_DONE: begin
                slice_load = 1'b1;
                state_nxt  = S_RESULT;
            end
            S_RESULT: if (res_fire) state_nxt = res.res_last ? S_IDLE : S_WAIT;
            S_WAIT:   if (wait_cnt == 2'(WAIT_CYCLES - 1)) state_nxt = S_INIT;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nq            <= '0;
            qidx          <= '0;
            qbase         <= '0;
            wdog          <= '0;
            wait_cnt      <= '0;
            qid           <= '0;
            rid           <= '0;
            timed_out     <= 1'b0;
            ref_read_addr <= '0;
            qeu_read_addr <= '0;
            ref_mem_read  <= 1'b0;
            dp_rst        <= 1'b1;
            dp_running    <= 1'b0;
            dbg_nquery    <= '0;
            dbg_first_qid <= '0;
        end else if (abort) begin
            qidx          <= '0;
            qbase         <= '0;
            ref_read_addr <= '0;
            qeu_read_addr <= '0;
            ref_mem_read  <= 1'b0;
            dp_rst        <= 1'b1;
            dp_running    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (state_nxt == S_INIT) begin
                    qidx <= '0;
                    nq   <= nq_clamped;
                end
                S_INIT: begin
                    qid           <= dataout_qeu;
                    rid           <= dataout_ref;
                    ref_read_addr <= REFMEM_PTR_WIDTH'(1);
                    qeu_read_addr <= qbase + QEUMEM_PTR_WIDTH'(1);
                    dp_rst        <= 1'b0;
                    dp_running    <= 1'b1;
                    ref_mem_read  <= 1'b1;
                    wdog          <= '0;
                    timed_out     <= 1'b0;
                    if (qidx == '0) dbg_first_qid <= 32'(dataout_qeu);
                end
                S_RUN: begin
                    ref_read_addr <= ref_read_addr + REFMEM_PTR_WIDTH'(1);
                    if (ref_read_addr < REFMEM_PTR_WIDTH'(SQG_SIZE + 2))
                        qeu_read_addr <= qeu_read_addr + QEUMEM_PTR_WIDTH'(1);
                    wdog      <= wdog + {{AXIS_WIDTH{1'b0}}, 1'b1};
                    timed_out <= !dp_done && wd_expired;
                end
                S_DONE: begin
                    dp_running    <= 1'b0;
                    ref_mem_read  <= 1'b0;
                    ref_read_addr <= '0;
                end
                S_RESULT: if (res_fire) begin
                    if (dbg_nquery != '1) dbg_nquery <= dbg_nquery + 32'd1;
                    dp_rst <= 1'b1;
                    if (res.res_last) begin
                        qidx          <= '0;
                        qbase         <= '0;
                        qeu_read_addr <= '0;
                    end else begin
                        qidx          <= qidx + NQ_W'(1);
                        qbase         <= qbase + QEUMEM_PTR_WIDTH'(QSTRIDE);
                        qeu_read_addr <= qbase + QEUMEM_PTR_WIDTH'(QSTRIDE);
                        wait_cnt      <= '0;
                    end
                end
                S_WAIT:  wait_cnt <= wait_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    dtw_res_slice #(.WIDTH(WIDTH)) u_res_slice (
        .clk      (clk),
        .rst      (rst),
        .clear    (slice_clear),
        .load     (slice_load),
        .qeu_id   (32'(qid)),
        .ref_id   (32'(rid)),
        .minval   (dp_minval),
        .position (dp_position),
        .hit      (dp_minval <= cfg_threshold),
        .last     (qidx == nq - NQ_W'(1)),
        .timeout  (timed_out),
        .res      (res)
    );

endmodule

// File: tb/tb_dtw_core_mq.sv
// tb/tb_dtw_core_mq.sv - directed self-checking bench for dtw_core_mq
module tb_dtw_core_mq;
    import dtw_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [3:0]  cfg_nquery;
    logic [15:0] cfg_threshold;
    logic        busy, ref_mem_read;
    logic [14:0] ref_read_addr;
    logic [15:0] dataout_ref;
    logic [31:0] ref_len;
    logic        ref_load_done;
    logic [10:0] qeu_read_addr;
    logic [15:0] dataout_qeu;
    logic        qeu_load_done;
    logic        dp_rst, dp_running, dp_done;
    logic [15:0] dp_minval;
    logic [31:0] dp_position;
    logic [2:0]  dbg_state;
    logic [31:0] dbg_nquery, dbg_first_qid;

    int checks = 0;
    int failures = 0;

    dtw_core_mq_if #(.WIDTH(16)) res_if ();

    always #5 clk = ~clk;

    dtw_core_mq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_nquery    (cfg_nquery),
        .cfg_threshold (cfg_threshold),
        .busy          (busy),
        .ref_mem_read  (ref_mem_read),
        .ref_read_addr (ref_read_addr),
        .dataout_ref   (dataout_ref),
        .ref_len       (ref_len),
        .ref_load_done (ref_load_done),
        .qeu_read_addr (qeu_read_addr),
        .dataout_qeu   (dataout_qeu),
        .qeu_load_done (qeu_load_done),
        .dp_rst        (dp_rst),
        .dp_running    (dp_running),
        .dp_done       (dp_done),
        .dp_minval     (dp_minval),
        .dp_position   (dp_position),
        .res           (res_if),
        .dbg_state     (dbg_state),
        .dbg_nquery    (dbg_nquery),
        .dbg_first_qid (dbg_first_qid)
    );

    // slot base words hold ids 0x0A00+slot; ref word 0 holds the ref id 0x00BE
    function automatic logic [15:0] qmem(input logic [10:0] a);
        if (a[7:0] == 8'd0) return 16'h0A00 + {13'd0, a[10:8]};
        return {5'd0, a};
    endfunction

    function automatic logic [15:0] rmem(input logic [14:0] a);
        if (a == 15'd0) return 16'h00BE;
        return {1'b0, a};
    endfunction

    always @(posedge clk) begin
        dataout_qeu <= qmem(qeu_read_addr);
        dataout_ref <= rmem(ref_read_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (dbg_state !== st && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {29'd0, dbg_state}, {29'd0, st});
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (res_if.res_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, res_if.res_valid}, 32'd1);
    endtask

    task automatic begin_batch(input logic [3:0] nq);
        cfg_nquery = nq;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic serve(input logic [15:0] mv, input logic [31:0] pos, input logic [10:0] qbase,
                         input string tag);
        int n = 0;
        while (dp_running !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_run"}, {31'd0, dp_running}, 32'd1);
        chk({tag, "_qaddr"}, {21'd0, qeu_read_addr}, {21'd0, qbase + 11'd1});
        chk({tag, "_raddr"}, {17'd0, ref_read_addr}, 32'd1);
        chk({tag, "_rd"}, {31'd0, ref_mem_read}, 32'd1);
        repeat (3) tick();
        dp_minval   = mv;
        dp_position = pos;
        dp_done     = 1'b1;
        tick();
        dp_done     = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] qid, input logic [15:0] mv,
                           input logic [31:0] pos, input logic hit, input logic last, input logic to);
        chk({tag, "_qid"}, res_if.res_qeu_id, qid);
        chk({tag, "_rid"}, res_if.res_ref_id, 32'h00BE);
        chk({tag, "_min"}, {16'd0, res_if.res_minval}, {16'd0, mv});
        chk({tag, "_pos"}, res_if.res_position, pos);
        chk({tag, "_hit"}, {31'd0, res_if.res_hit}, {31'd0, hit});
        chk({tag, "_last"}, {31'd0, res_if.res_last}, {31'd0, last});
        chk({tag, "_to"}, {31'd0, res_if.res_timeout}, {31'd0, to});
    endtask

    initial begin
        int   n;
        logic stable;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_nquery = 4'd3; cfg_threshold = 16'd100; ref_len = 32'd40;
        ref_load_done = 1'b1; qeu_load_done = 1'b1;
        dp_done = 1'b0; dp_minval = '0; dp_position = '0;
        res_if.res_ready = 1'b1;
        repeat (3) tick();
        chk("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dp_rst", {31'd0, dp_rst}, 32'd1);
        chk("rst_dp_running", {31'd0, dp_running}, 32'd0);
        chk("rst_valid", {31'd0, res_if.res_valid}, 32'd0);
        chk("rst_raddr", {17'd0, ref_read_addr}, 32'd0);
        chk("rst_qaddr", {21'd0, qeu_read_addr}, 32'd0);
        chk("rst_rd", {31'd0, ref_mem_read}, 32'd0);
        chk("rst_nquery", dbg_nquery, 32'd0);
        chk("rst_first_qid", dbg_first_qid, 32'd0);
        rst = 1'b0;
        tick();

        // reset in the middle of RUN
        begin_batch(4'd1);
        wait_state(S_RUN, 10, "mid_run_reach");
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, res_if.res_valid}, 32'd0);
        chk("mid_rst_dp_rst", {31'd0, dp_rst}, 32'd1);
        chk("mid_rst_raddr", {17'd0, ref_read_addr}, 32'd0);
        chk("mid_rst_qaddr", {21'd0, qeu_read_addr}, 32'd0);
        tick();

        // three queries, sink always ready; threshold boundary 100 vs 101
        begin_batch(4'd3);
        serve(16'd100, 32'd1000, 11'd0, "q0");
        wait_valid("q0_valid");
        chk_res("q0", 32'h0A00, 16'd100, 32'd1000, 1'b1, 1'b0, 1'b0);
        tick();
        serve(16'd101, 32'd1001, 11'd256, "q1");
        wait_valid("q1_valid");
        chk_res("q1", 32'h0A01, 16'd101, 32'd1001, 1'b0, 1'b0, 1'b0);
        tick();
        serve(16'd7, 32'd1002, 11'd512, "q2");
        wait_valid("q2_valid");
        chk_res("q2", 32'h0A02, 16'd7, 32'd1002, 1'b1, 1'b1, 1'b0);
        wait_state(S_IDLE, 5, "b3_idle");
        chk("b3_nquery", dbg_nquery, 32'd3);
        chk("b3_busy", {31'd0, busy}, 32'd0);
        chk("b3_first_qid", dbg_first_qid, 32'h0A00);

        // backpressure on the first result for 20 cycles
        res_if.res_ready = 1'b0;
        begin_batch(4'd2);
        serve(16'd55, 32'd2000, 11'd0, "bp0");
        wait_valid("bp0_valid");
        stable = 1'b1;
        repeat (20) begin
            if (!(res_if.res_valid === 1'b1 && dbg_state === S_RESULT &&
                  res_if.res_qeu_id === 32'h0A00 && res_if.res_minval === 16'd55 &&
                  res_if.res_position === 32'd2000 && res_if.res_last === 1'b0))
                stable = 1'b0;
            tick();
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        res_if.res_ready = 1'b1;
        tick();
        chk("bp_wait1", {29'd0, dbg_state}, {29'd0, S_WAIT});
        chk("bp_valid_drop", {31'd0, res_if.res_valid}, 32'd0);
        tick();
        tick();
        chk("bp_init3", {29'd0, dbg_state}, {29'd0, S_INIT});
        serve(16'd60, 32'd2001, 11'd256, "bp1");
        wait_valid("bp1_valid");
        chk_res("bp1", 32'h0A01, 16'd60, 32'd2001, 1'b1, 1'b1, 1'b0);
        wait_state(S_IDLE, 5, "bp_idle");
        chk("bp_nquery", dbg_nquery, 32'd5);

        // watchdog with no dp_done; cfg_nquery=0 is treated as one query
        ref_len   = 32'd1000;
        dp_minval = 16'd200;
        begin_batch(4'd0);
        wait_state(S_RUN, 10, "to_reach");
        n = 0;
        while (dbg_state === S_RUN && n < 2000) begin
            n++;
            tick();
        end
        chk("to_cycles", n, 32'd1315);
        wait_valid("to_valid");
        chk_res("to", 32'h0A00, 16'd200, 32'd2001, 1'b0, 1'b1, 1'b1);
        wait_state(S_IDLE, 5, "to_idle");
        chk("to_nquery", dbg_nquery, 32'd6);

        // abort while a result is pending
        ref_len = 32'd40;
        res_if.res_ready = 1'b0;
        begin_batch(4'd2);
        serve(16'd9, 32'd3000, 11'd0, "ab0");
        wait_valid("ab_valid");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid_drop", {31'd0, res_if.res_valid}, 32'd0);
        chk("ab_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_dp_rst", {31'd0, dp_rst}, 32'd1);
        chk("ab_dp_running", {31'd0, dp_running}, 32'd0);
        chk("ab_nquery", dbg_nquery, 32'd6);
        res_if.res_ready = 1'b1;

        // start without query memory loaded is dropped, not queued
        qeu_load_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("nostart_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        qeu_load_done = 1'b1;
        tick();
        tick();
        chk("noqueue_state", {29'd0, dbg_state}, {29'd0, S_IDLE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
